// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin merge of ALU and load writebacks onto one register-file write port
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    output logic             rf_we,
    output logic [4:0]       rf_addr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             last_grant
);
    logic acc0, acc1;
    // Under contention the requester that was not granted last wins; both readies never coincide then.
    assign req0_ready = rst & ~hold & (~req1_valid | last_grant);
    assign req1_ready = rst & ~hold & (~req0_valid | ~last_grant);
    assign acc0 = req0_valid & req0_ready;
    assign acc1 = req1_valid & req1_ready;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            last_grant <= 1'b1;
        end else begin
            // x0 writes are accepted and counted but never enable the write port
            rf_we <= (acc0 && req0_addr != 5'd0) || (acc1 && req1_addr != 5'd0);
            if (acc0 || acc1) begin
                rf_addr    <= acc1 ? req1_addr : req0_addr;
                rf_wdata   <= acc1 ? req1_data : req0_data;
                last_grant <= acc1;
            end
            if (acc0 && cnt0 != '1)
                cnt0 <= cnt0 + CNT_W'(1);
            if (acc1 && cnt1 != '1)
                cnt1 <= cnt1 + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with a write-port scoreboard for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        int          c;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic          clk, rst, hold;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]    req0_addr, req1_addr, rf_addr;
    logic [31:0]   req0_data, req1_data, rf_wdata;
    logic          rf_we, last_grant;
    logic [CW-1:0] cnt0, cnt1;

    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0, wseen = 0;
    int   ecnt0 = 0, ecnt1 = 0;
    logic elg = 1'b1;

    regfile_wb_arbiter #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cnt0(cnt0), .cnt1(cnt1), .last_grant(last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Write-port monitor: every rf_we pulse must match the oldest expected write, in its cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rf_we === 1'b1) begin
            wseen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none (cycle %0d)", rf_addr, rf_wdata, cyc);
            end else begin
                e = q.pop_front();
                chk("wr_cycle", cyc, e.c);
                chk("wr_addr", {27'd0, rf_addr}, {27'd0, e.a});
                chk("wr_data", rf_wdata, e.d);
            end
        end else if (q.size() != 0 && q[0].c <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: got no rf_we expected addr %0h data %0h (cycle %0d)", q[0].a, q[0].d, q[0].c);
            void'(q.pop_front());
        end
    end

    // One cycle of stimulus; g is the hand-computed grant (0 none, 1 req0, 2 req1).
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic h, input int g);
        @(posedge clk);
        #1;
        rst = 1'b1; hold = h;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        @(negedge clk);
        chk("accept0", {31'd0, req0_valid & req0_ready}, {31'd0, g == 1});
        chk("accept1", {31'd0, req1_valid & req1_ready}, {31'd0, g == 2});
        if (h) begin
            chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
            chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
        end
        chk("cnt0", {28'd0, cnt0}, ecnt0);
        chk("cnt1", {28'd0, cnt1}, ecnt1);
        chk("last_grant", {31'd0, last_grant}, {31'd0, elg});
        if (g == 1) begin
            if (ecnt0 != CMAX) ecnt0++;
            elg = 1'b0;
            if (a0 != 5'd0) q.push_back('{cyc + 1, a0, d0});
        end else if (g == 2) begin
            if (ecnt1 != CMAX) ecnt1++;
            elg = 1'b1;
            if (a1 != 5'd0) q.push_back('{cyc + 1, a1, d1});
        end
    endtask

    task automatic idle();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    endtask

    // Assert reset with both requesters valid; nothing may be accepted and all state must clear.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b0; hold = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hDEAD0000;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'hDEAD0001;
        @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_cnt0", {28'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {28'd0, cnt1}, 32'd0);
        chk("rst_last_grant", {31'd0, last_grant}, 32'd1);
        chk("rst_ready0_held", {31'd0, req0_ready}, 32'd0);
        ecnt0 = 0; ecnt1 = 0; elg = 1'b1;
    endtask

    initial begin
        int w0;
        rst = 1'b0; hold = 1'b0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
        do_reset(2);

        // contention straight out of reset: req0 first, then req1
        step(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'hBBBB0002, 0, 1);
        step(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'hBBBB0002, 0, 2);
        idle();
        chk("contend_cnt0", {28'd0, cnt0}, 32'd1);
        chk("contend_cnt1", {28'd0, cnt1}, 32'd1);
        idle();

        // x0 write: handshake and count, no write pulse
        do_reset(1);
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 2);
        idle();
        chk("x0_cnt1", {28'd0, cnt1}, 32'd1);
        idle();

        // hold with both valid: output drains, no grants, then round-robin resumes
        do_reset(1);
        step(1, 5'd7, 32'h00000011, 1, 5'd8, 32'h00000022, 0, 1);
        repeat (3) step(1, 5'd7, 32'h00000011, 1, 5'd8, 32'h00000022, 1, 0);
        step(1, 5'd7, 32'h00000033, 1, 5'd8, 32'h00000044, 0, 2);
        step(1, 5'd7, 32'h00000055, 1, 5'd8, 32'h00000066, 0, 1);
        idle();

        // saturation: 20 req0 acceptances, counter pins at 15
        do_reset(1);
        w0 = wseen;
        for (int i = 0; i < 20; i++)
            step(1, 5'((i % 31) + 1), 32'h100 + i, 0, 5'd0, 32'd0, 0, 1);
        idle();
        idle();
        chk("sat_cnt0", {28'd0, cnt0}, 32'd15);
        chk("sat_pulses", wseen - w0, 32'd20);

        // reset right after an acceptance: state cleared after the reset edge
        do_reset(1);
        step(1, 5'd3, 32'h12345678, 0, 5'd0, 32'd0, 0, 1);
        do_reset(1);
        chk("midrst_cnt0", {28'd0, cnt0}, 32'd0);

        // req1 streaming alone: four back-to-back writes in order
        step(0, 5'd0, 32'd0, 1, 5'd1, 32'hC0000001, 0, 2);
        step(0, 5'd0, 32'd0, 1, 5'd2, 32'hC0000002, 0, 2);
        step(0, 5'd0, 32'd0, 1, 5'd3, 32'hC0000003, 0, 2);
        step(0, 5'd0, 32'd0, 1, 5'd4, 32'hC0000004, 0, 2);
        idle();
        chk("stream_last_grant", {31'd0, last_grant}, 32'd1);
        chk("stream_cnt1", {28'd0, cnt1}, 32'd4);
        idle();
        idle();
        chk("queue_empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
- REQ-001 Parameter XLEN, default 32: width of write data.
- REQ-002 Parameter CNT_W, default 16: width of each grant-count statistic counter.
- REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1: rising-edge clock.
  - rst  in  1: synchronous active-low reset.
- REQ-004 hold  in  1: suppress new grants; the output stage still drains.
- REQ-005 Requester 0 (ALU writeback):
  - req0_valid  in  1: write request.
  - req0_addr  in  5: destination register.
  - req0_data  in  XLEN: write data.
  - req0_ready  out  1: request accepted this cycle.
- REQ-006 Requester 1 (load writeback):
  - req1_valid  in  1: write request.
  - req1_addr  in  5: destination register.
  - req1_data  in  XLEN: write data.
  - req1_ready  out  1: request accepted this cycle.
- REQ-007 Register-file write port, driving the single register-file write port:
  - rf_we  out  1: write enable.
  - rf_addr  out  5: write address.
  - rf_wdata  out  XLEN: write data.
- REQ-008 Grant-count outputs:
  - cnt0  out  CNT_W: accepted requests from requester 0.
  - cnt1  out  CNT_W: accepted requests from requester 1.
- REQ-009 last_grant  out  1: index of the most recently granted requester.

Function
- REQ-010 A handshake on requester N SHALL complete in a cycle iff reqN_valid and reqN_ready are both 1.
- REQ-011 The block SHALL accept at most one request per cycle.
- REQ-012 reqN_ready SHALL be combinational from the valids, hold and last_grant, and SHALL NOT depend on reqN_data.
- REQ-013 With hold=1, both ready outputs SHALL be 0.
- REQ-014 With hold=0 and exactly one valid, that requester SHALL be granted.
- REQ-015 With hold=0 and both valid, the requester not equal to last_grant SHALL be granted (round-robin).
- REQ-016 last_grant SHALL update to the granted index on each accepted request and SHALL hold otherwise.
- REQ-017 An accepted request SHALL load the output stage at the next clock edge, giving 1-cycle latency:
  - rf_addr = reqN_addr;
  - rf_wdata = reqN_data;
  - rf_we = 1 if reqN_addr != 0.
- REQ-018 An accepted request with addr 0 SHALL complete the handshake and be counted, but SHALL produce rf_we=0.
- REQ-019 rf_we SHALL be a single-cycle pulse per accepted nonzero-address request.
- REQ-020 With no acceptance in a cycle, rf_we SHALL be 0 in the next cycle; rf_addr and rf_wdata SHALL hold their previous values.
- REQ-021 Back-to-back acceptances on consecutive cycles SHALL produce rf_we on consecutive cycles, with no bubble.
- REQ-022 cntN SHALL increment by 1 on each accepted request from requester N.
- REQ-023 cntN SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
- REQ-024 A requester whose valid drops before it is granted SHALL NOT be counted or written.
- REQ-025 Arbitration fairness: a requester held valid SHALL be granted within 2 non-hold cycles.
- REQ-026 Ordering: two requests accepted in cycles t and t+1 SHALL appear on the write port in cycles t+1 and t+2 in the same order.

Reset
- REQ-027 While rst=0 at a rising edge, the following SHALL be cleared:
  - rf_we = 0;
  - rf_addr = 0;
  - rf_wdata = 0;
  - cnt0 = 0 and cnt1 = 0;
  - last_grant = 1, so requester 0 wins the first contention.
- REQ-028 While rst=0, both ready outputs SHALL be 0 and no request SHALL be accepted.
- REQ-029 A request accepted in the cycle before reset asserts SHALL be discarded: rf_we = 0 after the reset edge.
- REQ-030 All outputs SHALL be driven from a reset-defined state from the first edge with rst=0.

Verification
- REQ-031 Contention after reset: req0 (addr 5, data 0xAAAA0001) and req1 (addr 6, data 0xBBBB0002) both valid continuously from reset release. Required:
  - req0 granted first, then req1;
  - rf_we=1 with (5, 0xAAAA0001) followed by rf_we=1 with (6, 0xBBBB0002) on the next cycle;
  - cnt0=1 and cnt1=1 after two grants.
- REQ-032 x0 write: req1 valid with addr 0, data 0xFFFFFFFF. Required: req1_ready=1, rf_we stays 0 the next cycle, cnt1 increments to 1.
- REQ-033 Hold: hold=1 for 3 cycles with both requesters valid. Required:
  - both readies 0;
  - rf_we 0 after the first drained cycle;
  - grants resume on the first cycle after hold=0.
- REQ-034 Saturation with CNT_W=4: req0 valid alone for 20 cycles. Required: cnt0 stops at 15, with 20 rf_we pulses.
- REQ-035 Reset mid-stream: req0 accepted (addr 3, data 0x12345678) in the cycle before rst=0. Required:
  - rf_we=0 after the reset edge;
  - cnt0=0;
  - last_grant=1.
- REQ-036 Single requester streaming: req1 valid alone for 4 cycles with addrs 1-4. Required: 4 consecutive rf_we pulses with addrs 1,2,3,4 in order and last_grant=1.
